// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vram_arbiter
// Purpose : Shares one single-port synchronous video RAM between scan-out
//           reads, a single buffered writer and a clear-screen fill sequencer.
//           Optional macro VRAM_BYPASS_EN forwards writes to VgaData_o instead
//           of refetching.
// Rev     : 1.0  initial release
// ============================================================================
module vram_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] VgaAddress_i,
    output logic [DATA_WIDTH-1:0] VgaData_o,
    input  logic                  WrValid_i,
    output logic                  WrReady_o,
    input  logic [ADDR_WIDTH-1:0] WrAddress_i,
    input  logic [DATA_WIDTH-1:0] WrData_i,
    input  logic                  ClearStart_i,
    input  logic [DATA_WIDTH-1:0] ClearPattern_i,
    output logic                  ClearBusy_o,
    output logic [ADDR_WIDTH-1:0] RamAddress_o,
    output logic [DATA_WIDTH-1:0] RamData_o,
    output logic                  RamWrite_o,
    input  logic [DATA_WIDTH-1:0] RamData_i
);

    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_valid;
    logic                  refetch;
    logic                  hold_full;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [ADDR_WIDTH-1:0] clear_cnt;
    logic [DATA_WIDTH-1:0] clear_pat;
    logic                  clear_last;
    logic                  rd_pipe1;
    logic                  rd_pipe2;

    logic                  need_fetch;
    logic                  do_hold;
    logic                  do_clear;
    logic                  do_write;
    logic                  write_hits;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  accept_wr;
    logic                  accept_clr;
    logic                  busy_next;

    // Slot priority: scan-out fetch, then held write, then one clear step.
    always_comb begin
        need_fetch = !fetch_valid || (VgaAddress_i != fetch_addr) || refetch;
        do_hold    = !need_fetch && hold_full;
        do_clear   = !need_fetch && !hold_full && ClearBusy_o && !clear_last;
        do_write   = do_hold || do_clear;
        wr_addr    = do_hold ? hold_addr : clear_cnt;
        wr_data    = do_hold ? hold_data : clear_pat;
        write_hits = do_write && (wr_addr == fetch_addr);
        accept_wr  = WrValid_i && WrReady_o;
        accept_clr = ClearStart_i && !ClearBusy_o;
        busy_next  = accept_clr || (ClearBusy_o && !clear_last);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            RamAddress_o <= '0;
            RamData_o    <= '0;
            RamWrite_o   <= 1'b0;
            fetch_addr   <= '0;
            fetch_valid  <= 1'b0;
            refetch      <= 1'b0;
        end else if (need_fetch) begin
            RamAddress_o <= VgaAddress_i;
            RamWrite_o   <= 1'b0;
            fetch_addr   <= VgaAddress_i;
            fetch_valid  <= 1'b1;
            refetch      <= 1'b0;
        end else if (do_write) begin
            RamAddress_o <= wr_addr;
            RamData_o    <= wr_data;
            RamWrite_o   <= 1'b1;
`ifdef VRAM_BYPASS_EN
            refetch      <= 1'b0;
`else
            refetch      <= write_hits;
`endif
        end else begin
            RamWrite_o   <= 1'b0;
        end
    end

    // Ready is derived from the registered hold state, so it reopens one
    // cycle after the held write appears on the RAM bus.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hold_full <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
            WrReady_o <= 1'b1;
        end else begin
            if (accept_wr) begin
                hold_full <= 1'b1;
                hold_addr <= WrAddress_i;
                hold_data <= WrData_i;
            end else if (do_hold) begin
                hold_full <= 1'b0;
            end
            WrReady_o <= !hold_full && !accept_wr && !busy_next;
        end
    end

    // clear_last marks the cycle after the top address was issued; the
    // wrapped counter is ignored during it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ClearBusy_o <= 1'b0;
            clear_cnt   <= '0;
            clear_pat   <= '0;
            clear_last  <= 1'b0;
        end else if (accept_clr) begin
            ClearBusy_o <= 1'b1;
            clear_cnt   <= '0;
            clear_pat   <= ClearPattern_i;
            clear_last  <= 1'b0;
        end else if (clear_last) begin
            ClearBusy_o <= 1'b0;
            clear_last  <= 1'b0;
        end else if (do_clear) begin
            clear_cnt   <= clear_cnt + 1'b1;
            clear_last  <= (clear_cnt == {ADDR_WIDTH{1'b1}});
        end
    end

`ifdef VRAM_BYPASS_EN
    logic                  byp_pipe1;
    logic                  byp_pipe2;
    logic [DATA_WIDTH-1:0] byp_data1;
    logic [DATA_WIDTH-1:0] byp_data2;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            byp_pipe1 <= 1'b0;
            byp_pipe2 <= 1'b0;
            byp_data1 <= '0;
            byp_data2 <= '0;
        end else begin
            byp_pipe1 <= write_hits;
            byp_data1 <= wr_data;
            byp_pipe2 <= byp_pipe1;
            byp_data2 <= byp_data1;
        end
    end
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            VgaData_o <= '0;
            rd_pipe1  <= 1'b0;
            rd_pipe2  <= 1'b0;
        end else begin
            rd_pipe1 <= need_fetch;
            rd_pipe2 <= rd_pipe1;
`ifdef VRAM_BYPASS_EN
            if (byp_pipe2)
                VgaData_o <= byp_data2;
            else if (rd_pipe2)
                VgaData_o <= RamData_i;
`else
            if (rd_pipe2)
                VgaData_o <= RamData_i;
`endif
        end
    end

endmodule
`default_nettype wire
